ecc_operand_fifo: RTL and testbench

ECC_OPERAND_FIFO -- requirements
Module: ecc_operand_fifo

---
 rtl/ecc_operand_fifo.sv | 85 ++++++++
 tb/tb_ecc_operand_fifo.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/ecc_operand_fifo.sv
// ecc_operand_fifo: FIFO storing Hamming(38,32)-encoded operands, SEC decode and error counters on read
module ecc_operand_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [31:0]                wr_data,
  input  logic [37:0]                wr_err_mask,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [31:0]                rd_data,
  output logic [5:0]                 rd_syndrome,
  output logic                       rd_corrected,
  output logic                       rd_uncorrectable,
  output logic [7:0]                 corr_cnt,
  output logic [7:0]                 uncorr_cnt,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [37:0] c;
    int j;
    c = '0;
    j = 0;
    for (int i = 0; i < 38; i++)
      if (((i + 1) & i) != 0) begin
        c[i] = d[j];
        j++;
      end
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 38; i++)
        if (((i + 1) & i) != 0 && ((i + 1) & (1 << k)) != 0) c[(1 << k) - 1] ^= c[i];
    return c;
  endfunction
  function automatic logic [31:0] extract(input logic [37:0] c);
    logic [31:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < 38; i++)
      if (((i + 1) & i) != 0) begin
        d[j] = c[i];
        j++;
      end
    return d;
  endfunction
  logic [37:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [37:0] head, fixed;
  logic do_wr, do_rd;
  assign wr_ready = count != CW'(DEPTH);
  assign rd_valid = count != '0;
  assign do_wr = wr_valid && wr_ready;
  assign do_rd = rd_valid && rd_ready;
  assign head = mem[rp];
  always_comb begin
    rd_syndrome = '0;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 38; i++)
        if (((i + 1) & (1 << k)) != 0) rd_syndrome[k] ^= head[i];
  end
  assign rd_corrected = rd_syndrome != '0 && rd_syndrome <= 6'd38;
  assign rd_uncorrectable = rd_syndrome >= 6'd39;
  assign fixed = rd_corrected ? head ^ (38'd1 << (rd_syndrome - 6'd1)) : head;
  assign rd_data = extract(fixed);
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= encode(wr_data) ^ wr_err_mask;
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      corr_cnt <= '0;
      uncorr_cnt <= '0;
    end else begin
      wp <= wp + AW'(do_wr);
      rp <= rp + AW'(do_rd);
      count <= count + CW'(do_wr) - CW'(do_rd);
      corr_cnt <= corr_cnt + 8'(do_rd && rd_corrected && corr_cnt != 8'hff);
      uncorr_cnt <= uncorr_cnt + 8'(do_rd && rd_uncorrectable && uncorr_cnt != 8'hff);
    end
endmodule

// File: tb/tb_ecc_operand_fifo.sv
// tb_ecc_operand_fifo: randomized scoreboard bench for ecc_operand_fifo against a mask-based error model
module tb_ecc_operand_fifo;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 1;
  logic wr_valid = 0, rd_ready = 0;
  logic [31:0] wr_data = '0;
  logic [37:0] wr_err_mask = '0;
  logic wr_ready, rd_valid, rd_corrected, rd_uncorrectable;
  logic [31:0] rd_data;
  logic [5:0] rd_syndrome;
  logic [7:0] corr_cnt, uncorr_cnt;
  logic [$clog2(DEPTH):0] count;
  int total = 0, bad = 0;
  typedef struct {
    logic [31:0] data;
    int syn;
    logic corr;
    logic unc;
  } item_t;
  item_t q[$];
  int m_corr = 0, m_unc = 0;
  always #5 clk = ~clk;
  ecc_operand_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_err_mask(wr_err_mask), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_data(rd_data), .rd_syndrome(rd_syndrome),
    .rd_corrected(rd_corrected), .rd_uncorrectable(rd_uncorrectable),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .count(count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int dpos(input int j);
    int n = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        if (n == j) return p;
        n++;
      end
    return 0;
  endfunction
  // A clean codeword has syndrome 0, so the syndrome is the XOR of the
  // positions of the injected mask bits; whatever mask remains after the
  // single-bit correction lands on the data positions it covers.
  function automatic item_t expect_of(input logic [31:0] d, input logic [37:0] m);
    item_t it;
    logic [37:0] r;
    it.syn = 0;
    for (int i = 0; i < 38; i++) if (m[i]) it.syn ^= i + 1;
    it.corr = it.syn >= 1 && it.syn <= 38;
    it.unc = it.syn >= 39;
    r = m;
    if (it.corr) r[it.syn - 1] = ~r[it.syn - 1];
    it.data = d;
    for (int j = 0; j < 32; j++) it.data[j] = d[j] ^ r[dpos(j) - 1];
    return it;
  endfunction
  always @(negedge clk) begin
    int sz;
    item_t h;
    sz = q.size();
    if (reset) begin
      q.delete();
      m_corr = 0;
      m_unc = 0;
    end else begin
      chk("count", 64'(count), 64'(sz));
      chk("rd_valid", 64'(rd_valid), 64'(sz > 0));
      chk("wr_ready", 64'(wr_ready), 64'(sz < DEPTH));
      chk("corr_cnt", 64'(corr_cnt), 64'(m_corr));
      chk("uncorr_cnt", 64'(uncorr_cnt), 64'(m_unc));
      if (sz > 0) begin
        h = q[0];
        chk("rd_data", 64'(rd_data), 64'(h.data));
        chk("rd_syndrome", 64'(rd_syndrome), 64'(h.syn));
        chk("rd_corrected", 64'(rd_corrected), 64'(h.corr));
        chk("rd_uncorrectable", 64'(rd_uncorrectable), 64'(h.unc));
        if (rd_ready) begin
          void'(q.pop_front());
          if (h.corr && m_corr < 255) m_corr++;
          if (h.unc && m_unc < 255) m_unc++;
        end
      end
      if (wr_valid && sz < DEPTH) q.push_back(expect_of(wr_data, wr_err_mask));
    end
  end
  task automatic cyc(input logic wv, input logic [31:0] d, input logic [37:0] m, input logic rr, input logic rs);
    @(posedge clk);
    #1;
    wr_valid = wv;
    wr_data = d;
    wr_err_mask = m;
    rd_ready = rr;
    reset = rs;
  endtask
  function automatic logic [37:0] rmask();
    int k;
    logic [37:0] m;
    k = $urandom_range(0, 3);
    m = '0;
    if (k == 1) m[$urandom_range(0, 37)] = 1'b1;
    if (k == 2) begin
      m[$urandom_range(0, 37)] = 1'b1;
      m[$urandom_range(0, 37)] ^= 1'b1;
    end
    if (k == 3) m = 38'({$urandom, $urandom});
    return m;
  endfunction
  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'h1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("codeword", 64'(dut.mem[0]), 64'h7);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'hA5A5A5A5, 38'h20, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(1, 32'h0, (38'd1 << 37) | 38'd1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h100 + i, 0, 0, 0);
    cyc(1, 32'hDEAD, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cyc(1, 32'h200 + i, rmask(), 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 32'h300 + i, rmask(), 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'h400 + i, 0, 0, 0);
    cyc(1, 32'h4FF, 0, 1, 1);
    cyc(1, 32'h12345678, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 1) == 1, $urandom, rmask(), $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
